// File: rtl/dmux_scan_driver.sv
// Sequencer for a 1:4 demux: latches a 4-bit word and walks S through 0..3
// with Enable high, presenting word bit k on Data_in for HOLD_CYCLES each.
module dmux_scan_driver #(
  parameter int HOLD_CYCLES = 1,
  parameter int GAP_CYCLES  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] word_in,
  input  logic       word_valid,
  output logic       word_ready,
  input  logic       abort,
  output logic       Data_in,
  output logic [1:0] S,
  output logic       Enable,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_TC = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_TC  = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
  localparam bit         HAS_GAP = (GAP_CYCLES > 0);

  state_t     r_state;
  logic [3:0] r_word;
  logic [7:0] r_hold_cnt;
  logic [7:0] r_gap_cnt;
  logic       r_ready;
  logic       r_data;
  logic [1:0] r_sel;
  logic       r_en;
  logic       r_busy;
  logic       r_done;

  logic       w_hold_tc;
  logic       w_last_ch;
  logic       w_frame_end;
  logic [1:0] w_next_sel;

  assign w_hold_tc   = (r_hold_cnt == HOLD_TC);
  assign w_last_ch   = (r_sel == 2'd3);
  assign w_frame_end = abort || (w_hold_tc && w_last_ch);
  assign w_next_sel  = r_sel + 2'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_word     <= 4'd0;
      r_hold_cnt <= 8'd0;
      r_gap_cnt  <= 8'd0;
      r_ready    <= 1'b0;
      r_data     <= 1'b0;
      r_sel      <= 2'd0;
      r_en       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          // word_ready comes up one edge after reset release, so no word can
          // be taken on that first edge
          if (!r_ready) begin
            r_ready <= 1'b1;
          end else if (word_valid) begin
            r_word     <= word_in;
            r_ready    <= 1'b0;
            r_en       <= 1'b1;
            r_sel      <= 2'd0;
            r_data     <= word_in[0];
            r_busy     <= 1'b1;
            r_hold_cnt <= 8'd0;
            r_state    <= DRIVE;
          end
        end

        DRIVE: begin
          if (w_frame_end) begin
            r_en       <= 1'b0;
            r_data     <= 1'b0;
            r_sel      <= 2'd0;
            r_hold_cnt <= 8'd0;
            r_done     <= !abort;
            if (HAS_GAP) begin
              r_gap_cnt <= 8'd0;
              r_state   <= GAP;
            end else begin
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end
          end else if (w_hold_tc) begin
            r_sel      <= w_next_sel;
            r_data     <= r_word[w_next_sel];
            r_hold_cnt <= 8'd0;
          end else begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
          end
        end

        GAP: begin
          if (r_gap_cnt == GAP_TC) begin
            r_gap_cnt <= 8'd0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 8'd1;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign word_ready = r_ready;
  assign Data_in    = r_data;
  assign S          = r_sel;
  assign Enable     = r_en;
  assign busy       = r_busy;
  assign frame_done = r_done;

endmodule

// File: tb/tb_dmux_scan_driver.sv
// Four differently-parameterised drivers share one stimulus stream; each is
// compared every cycle against a frame-timing model derived from acceptance time.
module tb_dmux_scan_driver;

  localparam int NCFG = 4;
  int HC [NCFG] = '{1, 3, 2, 256};
  int GC [NCFG] = '{0, 2, 1, 3};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] word_in = 4'd0;
  logic       word_valid = 1'b0;
  logic       abort = 1'b0;

  logic [NCFG-1:0] rdy_o, dat_o, en_o, busy_o, fd_o;
  logic [1:0]      s_o [NCFG];

  int n_chk = 0;
  int n_err = 0;

  // model state
  int         n_edge = 0;
  bit         m_act [NCFG];
  bit         m_rdy [NCFG];
  bit         m_gap [NCFG];
  bit         m_fd  [NCFG];
  int         m_acc [NCFG];
  int         m_rdyat [NCFG];
  logic [3:0] m_word [NCFG];

  always #5 clk = ~clk;

  dmux_scan_driver #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) u_c0 (
    .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid),
    .word_ready(rdy_o[0]), .abort(abort), .Data_in(dat_o[0]), .S(s_o[0]),
    .Enable(en_o[0]), .busy(busy_o[0]), .frame_done(fd_o[0]));

  dmux_scan_driver #(.HOLD_CYCLES(3), .GAP_CYCLES(2)) u_c1 (
    .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid),
    .word_ready(rdy_o[1]), .abort(abort), .Data_in(dat_o[1]), .S(s_o[1]),
    .Enable(en_o[1]), .busy(busy_o[1]), .frame_done(fd_o[1]));

  dmux_scan_driver #(.HOLD_CYCLES(2), .GAP_CYCLES(1)) u_c2 (
    .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid),
    .word_ready(rdy_o[2]), .abort(abort), .Data_in(dat_o[2]), .S(s_o[2]),
    .Enable(en_o[2]), .busy(busy_o[2]), .frame_done(fd_o[2]));

  dmux_scan_driver #(.HOLD_CYCLES(256), .GAP_CYCLES(3)) u_c3 (
    .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid),
    .word_ready(rdy_o[3]), .abort(abort), .Data_in(dat_o[3]), .S(s_o[3]),
    .Enable(en_o[3]), .busy(busy_o[3]), .frame_done(fd_o[3]));

  task automatic chk_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (rdy,busy,done,en,S,data) at t=%0t",
               tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCFG; i++) begin
      m_act[i]   = 1'b0;
      m_rdy[i]   = 1'b0;
      m_gap[i]   = 1'b0;
      m_fd[i]    = 1'b0;
      m_acc[i]   = 0;
      m_word[i]  = 4'd0;
      m_rdyat[i] = n_edge + 1;
    end
  endtask

  // One clock edge of the frame-timing rules, using the inputs present at the edge.
  task automatic model_step();
    n_edge++;
    for (int i = 0; i < NCFG; i++) begin
      bit ended;
      ended   = 1'b0;
      m_fd[i] = 1'b0;
      if (m_act[i]) begin
        if (abort) begin
          ended = 1'b1;
        end else if (n_edge - m_acc[i] == 4 * HC[i]) begin
          ended   = 1'b1;
          m_fd[i] = 1'b1;
        end
        if (ended) begin
          m_act[i]   = 1'b0;
          m_gap[i]   = (GC[i] > 0);
          m_rdyat[i] = n_edge + GC[i];
        end
      end else if (m_rdy[i] && word_valid) begin
        m_act[i]  = 1'b1;
        m_acc[i]  = n_edge;
        m_word[i] = word_in;
        m_rdy[i]  = 1'b0;
      end
      if (!m_act[i] && !m_rdy[i] && n_edge >= m_rdyat[i]) begin
        m_rdy[i] = 1'b1;
        m_gap[i] = 1'b0;
      end
    end
  endtask

  function automatic logic [7:0] model_vec(input int i);
    int         k;
    logic [3:0] w;
    logic [1:0] s;
    logic       d;
    s = 2'd0;
    d = 1'b0;
    if (m_act[i]) begin
      k = (n_edge - m_acc[i]) / HC[i];
      w = m_word[i];
      s = 2'(k);
      d = w[k];
    end
    return {1'b0, m_rdy[i], m_act[i] | m_gap[i], m_fd[i], m_act[i], s, d};
  endfunction

  function automatic logic [7:0] dut_vec(input int i);
    return {1'b0, rdy_o[i], busy_o[i], fd_o[i], en_o[i], s_o[i], dat_o[i]};
  endfunction

  task automatic check_all(input string tag);
    for (int i = 0; i < NCFG; i++)
      chk_eq($sformatf("%s_cfg%0d", tag, i), dut_vec(i), model_vec(i));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    @(negedge clk);
    check_all(tag);
  endtask

  // Reset asserted between edges: outputs must fall with no clock edge.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all(tag);
    tick(tag);
    tick(tag);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (3) tick("reset");
    rst = 1'b0;
    tick("release");

    // single-cycle valid, word 1011
    word_in = 4'b1011;
    word_valid = 1'b1;
    tick("w1011");
    word_valid = 1'b0;
    word_in = 4'b0000;
    repeat (20) tick("w1011");

    // valid held high, word changed mid-frame
    word_in = 4'b0110;
    word_valid = 1'b1;
    tick("w0110");
    word_in = 4'b0001;
    repeat (40) tick("b2b");
    word_valid = 1'b0;
    repeat (20) tick("b2b");

    // abort mid-frame
    word_in = 4'b1101;
    word_valid = 1'b1;
    tick("abort");
    word_valid = 1'b0;
    repeat (2) tick("abort");
    abort = 1'b1;
    tick("abort");
    abort = 1'b0;
    repeat (12) tick("abort");

    // asynchronous reset mid-frame
    word_in = 4'b1111;
    word_valid = 1'b1;
    tick("arst");
    word_valid = 1'b0;
    repeat (4) tick("arst");
    async_reset("arst");
    word_in = 4'b0101;
    word_valid = 1'b1;
    repeat (12) tick("arst_after");

    // let the HOLD=256 instance complete at least one full frame
    word_valid = 1'b0;
    repeat (1100) tick("long");

    for (int c = 0; c < 4000; c++) begin
      word_valid = ($urandom_range(0, 3) != 0);
      word_in    = 4'($urandom_range(0, 15));
      abort      = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 999) == 0) async_reset("rnd_arst");
      else tick("rnd");
    end
    abort = 1'b0;
    word_valid = 1'b0;
    repeat (5) tick("tail");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
